lut_multiplier_seq_nb: RTL

//  Parametrised sequential successor to the combinational 2-bit LUT multiplier tree.
//  - Multiplies unsigned A (A_WIDTH) by unsigned B (B_WIDTH), one 2-bit digit of B per clock.
//  - Digit products come from a 4-entry LUT {0, A, 2A, 3A} built once per operation.
//  - Sits beside the lab multiplier tree. Trades latency for area.
//  - start/busy/done handshake with the surrounding test logic.

---
 rtl/lut_multiplier_seq_nb_if.sv | 31 +++
 rtl/lut_multiplier_seq_nb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lut_multiplier_seq_nb_if.sv
`default_nettype none
// ============================================================================
// Module   : lut_multiplier_seq_nb_if
// Brief    : start/busy/done handshake and operand/result bus of the
//            sequential LUT multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface lut_multiplier_seq_nb_if #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 8
);
    localparam int R_WIDTH = A_WIDTH + B_WIDTH;

    logic                 start_nb;
    logic [A_WIDTH-1:0]   source_a_nb;
    logic [B_WIDTH-1:0]   source_b_nb;
    logic                 busy_nb;
    logic                 done_nb;
    logic [R_WIDTH-1:0]   result_nb;

    modport master (
        output start_nb, source_a_nb, source_b_nb,
        input  busy_nb, done_nb, result_nb
    );

    modport slave (
        input  start_nb, source_a_nb, source_b_nb,
        output busy_nb, done_nb, result_nb
    );
endinterface
`default_nettype wire

// File: rtl/lut_multiplier_seq_nb.sv
`default_nettype none
// ============================================================================
// Module   : lut_multiplier_seq_nb
// Brief    : Sequential unsigned multiplier, one 2-bit digit of B per clock,
//            digit products from a {0, A, 2A, 3A} LUT built once per operation.
//            Optional macro LUT_MULT_EARLY_EXIT_EN stops once the remaining
//            digits of B are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module lut_multiplier_seq_nb #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 8
) (
    input  wire logic               clk_nb,
    input  wire logic               reset_nb,
    lut_multiplier_seq_nb_if.slave  mul
);
    localparam int R_WIDTH  = A_WIDTH + B_WIDTH;
    localparam int N_DIGITS = B_WIDTH / 2;
    localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    if (A_WIDTH < 2) begin : g_chk_a_width
        $error("lut_multiplier_seq_nb: A_WIDTH must be >= 2");
    end
    if ((B_WIDTH < 2) || ((B_WIDTH % 2) != 0)) begin : g_chk_b_width
        $error("lut_multiplier_seq_nb: B_WIDTH must be even and >= 2");
    end

    logic [1:0]           state_q,  state_d;
    logic [A_WIDTH-1:0]   a_q,      a_d;
    logic [B_WIDTH-1:0]   b_q,      b_d;
    logic [R_WIDTH-1:0]   lut_q [4];
    logic [R_WIDTH-1:0]   lut_d [4];
    logic [R_WIDTH-1:0]   acc_q,    acc_d;
    logic [R_WIDTH-1:0]   result_q, result_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;

    logic [IDX_W:0]       w_shift;
    logic [1:0]           w_digit;
    logic [R_WIDTH-1:0]   w_term;
    logic [R_WIDTH-1:0]   w_sum;
    logic                 w_last;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_nb) begin
        if (reset_nb) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            lut_q    <= '{default: '0};
            acc_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lut_q    <= lut_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            idx_q    <= idx_d;
        end
    end

    // Digit i carries weight 4^i, i.e. a left shift of 2i.
    always_comb begin
        w_shift = {idx_q, 1'b0};
        w_digit = b_q[w_shift +: 2];
        w_term  = lut_q[w_digit] << w_shift;
        w_sum   = acc_q + w_term;
    end

`ifdef LUT_MULT_EARLY_EXIT_EN
    logic [IDX_W+1:0] w_upper_shift;

    always_comb begin
        w_upper_shift = {1'b0, idx_q, 1'b0} + (IDX_W + 2)'(2);
        w_last        = (idx_q == C_LAST_IDX) || ((b_q >> w_upper_shift) == '0);
    end
`else
    always_comb begin
        w_last = (idx_q == C_LAST_IDX);
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul.start_nb) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   if (w_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        lut_d    = lut_q;
        acc_d    = acc_q;
        result_d = result_q;
        idx_d    = idx_q;
        case (state_q)
            S_IDLE: begin
                if (mul.start_nb) begin
                    a_d = mul.source_a_nb;
                    b_d = mul.source_b_nb;
                end
            end
            S_LOAD: begin
                lut_d[0] = '0;
                lut_d[1] = R_WIDTH'(a_q);
                lut_d[2] = R_WIDTH'(a_q) << 1;
                lut_d[3] = (R_WIDTH'(a_q) << 1) + R_WIDTH'(a_q);
                acc_d    = '0;
                idx_d    = '0;
            end
            S_RUN: begin
                acc_d = w_sum;
                // Result is captured on the way into DONE so it is already
                // valid in the cycle done_nb is high.
                if (w_last) begin
                    result_d = w_sum;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mul.busy_nb   = (state_q == S_LOAD) || (state_q == S_RUN);
        mul.done_nb   = (state_q == S_DONE);
        mul.result_nb = result_q;
    end

endmodule
`default_nettype wire
